// File: rtl/maze_pkg.sv
// Shared definitions for the maze game controller: state encodings,
// direction-pulse bit positions and default map dimensions.
package maze_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_REVEAL = 3'd1,
        ST_PLAY   = 3'd2,
        ST_FETCH  = 3'd3,
        ST_CHECK  = 3'd4,
        ST_WON    = 3'd5,
        ST_LOST   = 3'd6
    } state_t;

    localparam int DIR_UP    = 0;
    localparam int DIR_DOWN  = 1;
    localparam int DIR_LEFT  = 2;
    localparam int DIR_RIGHT = 3;

    localparam int DEFAULT_MAP_W = 30;
    localparam int DEFAULT_MAP_H = 21;

endpackage

// File: rtl/maze_game_ctrl_if.sv
// Map ROM bus: the controller drives the row address, the ROM returns the
// whole row one cycle later (bit x = column x, 1 = wall).
interface maze_game_ctrl_if
    import maze_pkg::*;
#(
    parameter int MAP_W = DEFAULT_MAP_W,
    parameter int MAP_H = DEFAULT_MAP_H
);
    logic [$clog2(MAP_H)-1:0] map_addr;
    logic [MAP_W-1:0]         map_row;

    modport master (output map_addr, input map_row);
    modport slave  (input map_addr, output map_row);
endinterface

// File: rtl/reveal_timer.sv
// Counts cycles while the map is being shown; done flags the last one.
module reveal_timer #(
    parameter int REVEAL_CYCLES = 25_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic done
);
    localparam int CW = $clog2(REVEAL_CYCLES + 1);

    logic [CW-1:0] cnt_q;

    assign done = (cnt_q == CW'(REVEAL_CYCLES - 1));

    // Count up while enabled, saturating at the terminal value.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt_q <= '0;
        end else if (enable && !done) begin
            cnt_q <= cnt_q + CW'(1);
        end
    end
endmodule

// File: rtl/maze_game_ctrl.sv
// Maze game state controller: menu/reveal/play/win/lose sequencing, player
// position, lives, and wall checking through a registered ROM lookup.
module maze_game_ctrl
    import maze_pkg::*;
#(
    parameter int MAP_W         = DEFAULT_MAP_W,
    parameter int MAP_H         = DEFAULT_MAP_H,
    parameter int REVEAL_CYCLES = 25_000_000,
    parameter int START_X       = 0,
    parameter int START_Y       = 11,
    parameter int GOAL_X        = 29,
    parameter int GOAL_Y        = 11,
    parameter int LIVES         = 3
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [3:0]                 dir,
    maze_game_ctrl_if.master           rom,
    output logic [$clog2(MAP_W)-1:0]   player_x,
    output logic [$clog2(MAP_H)-1:0]   player_y,
    output logic [3:0]                 lives_left,
    output logic [2:0]                 state,
    output logic                       map_visible,
    output logic                       won,
    output logic                       lost
);
    localparam int XW = $clog2(MAP_W);
    localparam int YW = $clog2(MAP_H);

    state_t        state_q, state_d;
    logic [XW-1:0] px_q, px_d, tx_q, tx_d, tgt_x;
    logic [YW-1:0] py_q, py_d, ty_q, ty_d, tgt_y;
    logic [YW-1:0] addr_q, addr_d;
    logic [3:0]    lives_q, lives_d;
    logic          vis_q, vis_d, won_q, won_d, lost_q, lost_d;
    logic          move_ok;
    logic          timer_clr, timer_en, reveal_done;

    assign timer_en  = (state_q == ST_REVEAL);
    assign timer_clr = !timer_en;

    reveal_timer #(.REVEAL_CYCLES(REVEAL_CYCLES)) u_reveal_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (timer_clr),
        .enable (timer_en),
        .done   (reveal_done)
    );

    // Next-state, move evaluation and registered-output precomputation.
    always_comb begin
        state_d = state_q;
        px_d    = px_q;
        py_d    = py_q;
        tx_d    = tx_q;
        ty_d    = ty_q;
        addr_d  = addr_q;
        lives_d = lives_q;
        tgt_x   = px_q;
        tgt_y   = py_q;
        move_ok = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_REVEAL;
                    px_d    = XW'(START_X);
                    py_d    = YW'(START_Y);
                    lives_d = 4'(LIVES);
                end
            end
            ST_REVEAL: begin
                if (reveal_done) state_d = ST_PLAY;
            end
            ST_PLAY: begin
                if ($onehot(dir)) begin
                    if (dir[DIR_UP] && py_q != '0) begin
                        tgt_y   = py_q - YW'(1);
                        move_ok = 1'b1;
                    end else if (dir[DIR_DOWN] && py_q != YW'(MAP_H - 1)) begin
                        tgt_y   = py_q + YW'(1);
                        move_ok = 1'b1;
                    end else if (dir[DIR_LEFT] && px_q != '0) begin
                        tgt_x   = px_q - XW'(1);
                        move_ok = 1'b1;
                    end else if (dir[DIR_RIGHT] && px_q != XW'(MAP_W - 1)) begin
                        tgt_x   = px_q + XW'(1);
                        move_ok = 1'b1;
                    end
                end
                if (move_ok) begin
                    tx_d    = tgt_x;
                    ty_d    = tgt_y;
                    addr_d  = tgt_y;
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: state_d = ST_CHECK;
            ST_CHECK: begin
                if (rom.map_row[tx_q]) begin
                    lives_d = lives_q - 4'd1;
                    px_d    = XW'(START_X);
                    py_d    = YW'(START_Y);
                    state_d = (lives_q == 4'd1) ? ST_LOST : ST_REVEAL;
                end else begin
                    px_d    = tx_q;
                    py_d    = ty_q;
                    state_d = (tx_q == XW'(GOAL_X) && ty_q == YW'(GOAL_Y)) ? ST_WON : ST_PLAY;
                end
            end
            ST_WON, ST_LOST: begin
                if (start) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        vis_d  = (state_d == ST_REVEAL) || (state_d == ST_WON) || (state_d == ST_LOST);
        won_d  = (state_d == ST_WON);
        lost_d = (state_d == ST_LOST);
    end

    // State and output registers; flags are registered from the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            px_q    <= XW'(START_X);
            py_q    <= YW'(START_Y);
            tx_q    <= '0;
            ty_q    <= '0;
            addr_q  <= '0;
            lives_q <= 4'(LIVES);
            vis_q   <= 1'b0;
            won_q   <= 1'b0;
            lost_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            px_q    <= px_d;
            py_q    <= py_d;
            tx_q    <= tx_d;
            ty_q    <= ty_d;
            addr_q  <= addr_d;
            lives_q <= lives_d;
            vis_q   <= vis_d;
            won_q   <= won_d;
            lost_q  <= lost_d;
        end
    end

    assign rom.map_addr = addr_q;
    assign player_x     = px_q;
    assign player_y     = py_q;
    assign lives_left   = lives_q;
    assign state        = state_q;
    assign map_visible  = vis_q;
    assign won          = won_q;
    assign lost         = lost_q;
endmodule

// File: tb/tb_maze_game_ctrl.sv
// Bench for maze_game_ctrl: random map, random and directed moves, checked
// against a move-level game model.
module tb_maze_game_ctrl;
    import maze_pkg::*;

    localparam int W = 30;
    localparam int H = 21;
    localparam int RC = 8;
    localparam int SX = 0, SY = 11, GX = 29, GY = 11, NL = 3;

    localparam int P_MENU = 0, P_REVEAL = 1, P_PLAY = 2, P_WON = 3, P_LOST = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [3:0] dir = '0;
    logic [4:0] player_x, player_y;
    logic [3:0] lives_left;
    logic [2:0] state;
    logic       map_visible, won, lost;

    logic [W-1:0] rom [H];

    int n_cmp = 0;
    int n_err = 0;

    int m_x, m_y, m_lives, m_phase, m_addr;

    maze_game_ctrl_if #(.MAP_W(W), .MAP_H(H)) rom_if ();

    maze_game_ctrl #(
        .MAP_W(W), .MAP_H(H), .REVEAL_CYCLES(RC),
        .START_X(SX), .START_Y(SY), .GOAL_X(GX), .GOAL_Y(GY), .LIVES(NL)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .dir         (dir),
        .rom         (rom_if.master),
        .player_x    (player_x),
        .player_y    (player_y),
        .lives_left  (lives_left),
        .state       (state),
        .map_visible (map_visible),
        .won         (won),
        .lost        (lost)
    );

    always #5 clk = ~clk;

    // Synchronous ROM: data for an address appears one edge later.
    always @(posedge clk) rom_if.map_row <= rom[rom_if.map_addr];

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [2:0] exp_code(input int p);
        case (p)
            P_MENU:   return ST_IDLE;
            P_REVEAL: return ST_REVEAL;
            P_PLAY:   return ST_PLAY;
            P_WON:    return ST_WON;
            default:  return ST_LOST;
        endcase
    endfunction

    function automatic logic [19:0] exp_vec();
        logic vis;
        vis = (m_phase == P_REVEAL) || (m_phase == P_WON) || (m_phase == P_LOST);
        return {exp_code(m_phase), 5'(m_x), 5'(m_y), 4'(m_lives), vis,
                m_phase == P_WON, m_phase == P_LOST};
    endfunction

    function automatic logic [19:0] dut_vec();
        return {state, player_x, player_y, lives_left, map_visible, won, lost};
    endfunction

    task automatic model_reset();
        m_x = SX; m_y = SY; m_lives = NL; m_phase = P_MENU; m_addr = 0;
    endtask

    task automatic wait_reveal();
        int cnt = 0;
        while (map_visible === 1'b1 && state === ST_REVEAL && cnt < 100) begin
            cnt++;
            dir   = 4'($urandom_range(0, 15));
            start = 1'($urandom_range(0, 1));
            tick();
        end
        dir = '0;
        start = 1'b0;
        m_phase = P_PLAY;
        n_cmp++;
        if (cnt != RC)
            $display("FAIL reveal_len: got %0d cycles, expected %0d", cnt, RC);
        if (cnt != RC) n_err++;
        n_cmp++;
        if (dut_vec() !== exp_vec()) begin
            n_err++;
            $display("FAIL after_reveal: got %h, expected %h", dut_vec(), exp_vec());
        end
    endtask

    task automatic new_game();
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        model_reset();
        start = 1'b1;
        tick();
        start = 1'b0;
        m_phase = P_REVEAL;
        wait_reveal();
    endtask

    task automatic do_move(input logic [3:0] d);
        int  nx = m_x, ny = m_y;
        bit  valid = ($countones(d) == 1);
        if (valid) begin
            if (d[0])      ny = m_y - 1;
            else if (d[1]) ny = m_y + 1;
            else if (d[2]) nx = m_x - 1;
            else           nx = m_x + 1;
            if (nx < 0 || nx >= W || ny < 0 || ny >= H) valid = 0;
        end
        dir = d;
        tick();
        dir = '0;
        if (!valid) begin
            n_cmp++;
            if (state !== ST_PLAY || rom_if.map_addr !== 5'(m_addr)) begin
                n_err++;
                $display("FAIL ignored_move dir=%b: state=%0d addr=%0d, expected state=%0d addr=%0d",
                         d, state, rom_if.map_addr, ST_PLAY, m_addr);
            end
            tick(); tick();
            n_cmp++;
            if (dut_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL ignored_hold dir=%b: got %h, expected %h", d, dut_vec(), exp_vec());
            end
            return;
        end
        m_addr = ny;
        n_cmp++;
        if (state !== ST_FETCH || rom_if.map_addr !== 5'(ny)) begin
            n_err++;
            $display("FAIL fetch dir=%b: state=%0d addr=%0d, expected state=%0d addr=%0d",
                     d, state, rom_if.map_addr, ST_FETCH, ny);
        end
        dir = 4'($urandom_range(0, 15)); start = 1'($urandom_range(0, 1));
        tick();
        dir = 4'($urandom_range(0, 15)); start = 1'($urandom_range(0, 1));
        tick();
        dir = '0; start = 1'b0;
        if (rom[ny][nx]) begin
            m_lives--;
            m_x = SX; m_y = SY;
            m_phase = (m_lives == 0) ? P_LOST : P_REVEAL;
        end else begin
            m_x = nx; m_y = ny;
            m_phase = (nx == GX && ny == GY) ? P_WON : P_PLAY;
        end
        n_cmp++;
        if (dut_vec() !== exp_vec()) begin
            n_err++;
            $display("FAIL move_result dir=%b to (%0d,%0d): got %h, expected %h",
                     d, nx, ny, dut_vec(), exp_vec());
        end
        if (m_phase == P_REVEAL) wait_reveal();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        model_reset();
        n_cmp++;
        if (dut_vec() !== exp_vec() || rom_if.map_addr !== 5'd0) begin
            n_err++;
            $display("FAIL reset_state: got %h addr=%0d, expected %h addr=0",
                     dut_vec(), rom_if.map_addr, exp_vec());
        end
    endtask

    task automatic test_reveal();
        new_game();
    endtask

    task automatic test_move_right();
        new_game();
        dir = 4'b1000;
        tick();
        dir = '0;
        n_cmp++;
        if (rom_if.map_addr !== 5'd11 || state !== ST_FETCH) begin
            n_err++;
            $display("FAIL right_fetch: addr=%0d state=%0d, expected addr=11 state=%0d",
                     rom_if.map_addr, state, ST_FETCH);
        end
        tick();
        n_cmp++;
        if (player_x !== 5'd0 || state !== ST_CHECK) begin
            n_err++;
            $display("FAIL right_early: x=%0d state=%0d, expected x=0 state=%0d",
                     player_x, state, ST_CHECK);
        end
        tick();
        m_x = 1; m_addr = 11; m_phase = P_PLAY;
        n_cmp++;
        if (dut_vec() !== exp_vec()) begin
            n_err++;
            $display("FAIL right_done: got %h, expected %h", dut_vec(), exp_vec());
        end
        do_move(4'b0100);
    endtask

    task automatic test_ignored();
        new_game();
        do_move(4'b0100);
        do_move(4'b0011);
        do_move(4'b0000);
        do_move(4'b1111);
    endtask

    task automatic test_wall();
        new_game();
        for (int i = 0; i < NL; i++) do_move(4'b0001);
        n_cmp++;
        if (lost !== 1'b1 || lives_left !== 4'd0 || state !== ST_LOST) begin
            n_err++;
            $display("FAIL wall_lost: lost=%b lives=%0d state=%0d, expected 1/0/%0d",
                     lost, lives_left, state, ST_LOST);
        end
    endtask

    task automatic test_win();
        new_game();
        for (int i = 0; i < GX; i++) do_move(4'b1000);
        n_cmp++;
        if (won !== 1'b1 || state !== ST_WON || player_x !== 5'(GX)) begin
            n_err++;
            $display("FAIL win: won=%b state=%0d x=%0d, expected 1/%0d/%0d",
                     won, state, player_x, ST_WON, GX);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        n_cmp++;
        if (state !== ST_IDLE || won !== 1'b0 || lost !== 1'b0 || map_visible !== 1'b0) begin
            n_err++;
            $display("FAIL win_to_idle: state=%0d won=%b lost=%b vis=%b, expected %0d/0/0/0",
                     state, won, lost, map_visible, ST_IDLE);
        end
    endtask

    task automatic test_random_play();
        new_game();
        for (int i = 0; i < 200; i++) begin
            do_move(4'($urandom_range(0, 15)));
            if (m_phase == P_WON || m_phase == P_LOST) begin
                start = 1'b1;
                tick();
                start = 1'b0;
                m_phase = P_MENU;
                n_cmp++;
                if (state !== ST_IDLE || won !== 1'b0 || lost !== 1'b0 || map_visible !== 1'b0) begin
                    n_err++;
                    $display("FAIL rand_to_idle: state=%0d won=%b lost=%b vis=%b",
                             state, won, lost, map_visible);
                end
                start = 1'b1;
                tick();
                start = 1'b0;
                m_x = SX; m_y = SY; m_lives = NL; m_phase = P_REVEAL;
                wait_reveal();
            end
        end
    endtask

    task automatic test_reset_in_check();
        new_game();
        dir = 4'b1000;
        tick();
        dir = '0;
        tick();
        n_cmp++;
        if (state !== ST_CHECK) begin
            n_err++;
            $display("FAIL pre_reset_check: state=%0d, expected %0d", state, ST_CHECK);
        end
        reset = 1'b1;
        tick();
        model_reset();
        n_cmp++;
        if (dut_vec() !== exp_vec() || rom_if.map_addr !== 5'd0) begin
            n_err++;
            $display("FAIL reset_in_check: got %h addr=%0d, expected %h addr=0",
                     dut_vec(), rom_if.map_addr, exp_vec());
        end
        reset = 1'b0;
    endtask

    initial begin
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                rom[y][x] = ($urandom_range(0, 3) == 0);
        rom[SY] = '0;
        rom[SY - 1][0] = 1'b1;

        test_reset();
        test_reveal();
        test_move_right();
        test_ignored();
        test_wall();
        test_win();
        test_random_play();
        test_reset_in_check();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/maze_game_ctrl.md
# maze_game_ctrl

Parametrised game-state controller for the maze game: owns the menu/reveal/play/win/lose state machine, player tile position, lives, and wall collision checking against the map ROM. Sits between the debounced direction pulses and the VGA renderer; the renderer reads `player_x`, `player_y`, `map_visible` and `state`. It generalises the first-generation logic with arbitrary map size, a timed map reveal, a registered ROM lookup per move, a goal tile and a lives counter.

## Interface

- `MAP_W`, 30, map width in tiles (≥2)
- `MAP_H`, 21, map height in tiles (≥2)
- `REVEAL_CYCLES`, 25_000_000, `clk` cycles the map is shown after start (≥1)
- `START_X` / `START_Y`, 0 / 11, spawn tile
- `GOAL_X` / `GOAL_Y`, 29 / 11, goal tile
- `LIVES`, 3, lives per game (1..15)
- `clk`  in  1  system clock
- `reset`  in  1  synchronous, active-high
- `start`  in  1  one-cycle pulse: begin game / return to menu
- `dir`  in  4  one-cycle move pulses, [0]=up [1]=down [2]=left [3]=right
- `map_addr`  out  clog2(MAP_H)  registered ROM row address
- `map_row`  in  MAP_W  ROM data, valid one cycle after `map_addr` changes; bit x = column x, 1 = wall
- `player_x`  out  clog2(MAP_W)  player column
- `player_y`  out  clog2(MAP_H)  player row
- `lives_left`  out  4  remaining lives
- `state`  out  3  current FSM state encoding
- `map_visible`  out  1  renderer shows walls
- `won`, `lost`  out  1  level flags, high in WON / LOST

## Operation

- States: IDLE, REVEAL, PLAY, FETCH, CHECK, WON, LOST.
- IDLE: `start` → REVEAL, reveal counter cleared, player at spawn, lives = `LIVES`.
- REVEAL: `map_visible`=1; counter increments each cycle; at `REVEAL_CYCLES`-1 → PLAY. `dir` ignored.
- PLAY: `dir` accepted only if exactly one bit set; multi-bit or zero ignored. Target = position ±1 on the axis; targets outside 0..MAP_W-1 / 0..MAP_H-1 are ignored (no state change). Valid target latched, `map_addr` ← target y, → FETCH.
- FETCH: wait one cycle for ROM → CHECK.
- CHECK: if `map_row[target_x]`=1 → wall hit: `lives_left` −1, player to spawn; if it was 1 → LOST, else → REVEAL (map re-shown, counter cleared). Else player ← target; if target = goal → WON, else → PLAY.
- `dir` during REVEAL/FETCH/CHECK/WON/LOST is dropped, not queued.
- WON/LOST: hold position and flags; `start` → IDLE.
- `start` in REVEAL/PLAY/FETCH/CHECK is ignored.
- `map_visible` = 1 in REVEAL, WON, LOST; 0 elsewhere.

## Timing

- Reset (overrides all, any state): state=IDLE, `player_x`=START_X, `player_y`=START_Y, `lives_left`=LIVES, `map_addr`=0, `map_visible`=0, `won`=`lost`=0, counter=0.
- All outputs registered; no combinational input→output paths.
- Move latency: `dir` pulse in cycle t (PLAY) → position/state update visible at t+3.
- Reveal length: exactly `REVEAL_CYCLES` cycles in REVEAL.
- Accepted move rate: at most one per 3 cycles.
- Counter width clog2(REVEAL_CYCLES+1); no wrap.
- Goal tile inside a wall is a configuration error; not checked.

## Structure

- Shared package `maze_pkg`: state encodings, `dir` bit indices, default map dimensions.
- Sub-module `reveal_timer` (clear, enable, done at `REVEAL_CYCLES`-1); remainder inline.

## Test plan

- Reset then `start`, `REVEAL_CYCLES`=8 → `map_visible` high exactly 8 cycles, then state=PLAY, player (0,11).
- Right pulse into open tile (1,11) → `map_addr`=11, player_x=1 three cycles later, state PLAY.
- Left pulse at x=0, and `dir`=4'b0011 → no state change, no FETCH.
- Move into wall with lives 3 → lives 2, player (0,11), state REVEAL; repeat to lives 0 → LOST, `lost`=1.
- Path to (29,11) → WON, `won`=1; `start` → IDLE, flags clear.
- Assert `reset` during CHECK → all outputs at reset values next cycle.
